// File: rtl/reg_read_scoreboard_if.sv
// Decode / register-read / writeback bundle for the register-read scoreboard.
// The master side is the pipeline (decode, RR stage, WB). The slave side is the scoreboard.
interface reg_read_scoreboard_if #(
    parameter int IDX_W = 3
);
    // Handshake: an instruction moves into register read in exactly the cycle where
    // issue=1. issue is a same-cycle function of dec_valid, rr_ready and the interlock state.
    // Decode must hold its fields stable while dec_stall=1. wb_we has no back-pressure.
    logic             dec_valid;
    logic [IDX_W-1:0] dec_src1_idx;
    logic             dec_src1_used;
    logic [IDX_W-1:0] dec_src2_idx;
    logic             dec_src2_used;
    logic [IDX_W-1:0] dec_dst_idx;
    logic             dec_dst_we;
    logic             rr_ready;
    logic             wb_we;
    logic [IDX_W-1:0] wb_idx;
    logic             issue;
    logic             dec_stall;

    modport master (
        output dec_valid, dec_src1_idx, dec_src1_used, dec_src2_idx, dec_src2_used,
        output dec_dst_idx, dec_dst_we, rr_ready, wb_we, wb_idx,
        input  issue, dec_stall
    );

    modport slave (
        input  dec_valid, dec_src1_idx, dec_src1_used, dec_src2_idx, dec_src2_used,
        input  dec_dst_idx, dec_dst_we, rr_ready, wb_we, wb_idx,
        output issue, dec_stall
    );
endinterface

// File: rtl/reg_read_scoreboard.sv
// Register-read issue interlock: per-register pending-write counters, a RAW/saturation hazard
// check, and a drain FSM that holds off issue until every in-flight write has retired.
module reg_read_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    reg_read_scoreboard_if.slave bus,
    input  logic                drain_req,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                drain_done,
    output logic                wb_underflow,
    output logic [15:0]         stall_cycles,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state;
    logic [CNT_W-1:0]    cnt     [NUM_REGS];
    logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_hit;
    logic [NUM_REGS-1:0] dec_hit;
    logic                hazard;
    logic                inc_en;
    logic                underflow_now;
    logic                all_zero_nxt;

    // The hazard looks at the pre-update counts: a same-cycle WB never bypasses.
    always_comb begin
        hazard = 1'b0;
        if (bus.dec_src1_used && (cnt[bus.dec_src1_idx] != '0))
            hazard = 1'b1;
        if (bus.dec_src2_used && (cnt[bus.dec_src2_idx] != '0))
            hazard = 1'b1;
        if (bus.dec_dst_we && (cnt[bus.dec_dst_idx] == CNT_MAX))
            hazard = 1'b1;
    end

    assign bus.issue     = bus.dec_valid & bus.rr_ready & ~hazard
                         & (state == ST_RUN) & ~drain_req;
    assign bus.dec_stall = bus.dec_valid & ~bus.issue;
    assign inc_en        = bus.issue & bus.dec_dst_we;
    assign state_dbg     = state;

    always_comb begin
        underflow_now = 1'b0;
        all_zero_nxt  = 1'b1;
        inc_hit       = '0;
        dec_hit       = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_hit[i] = inc_en & (bus.dec_dst_idx == IDX_W'(i));
            dec_hit[i] = bus.wb_we & (bus.wb_idx == IDX_W'(i));
            cnt_nxt[i] = cnt[i];
            if (inc_hit[i] && !dec_hit[i]) begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end else if (dec_hit[i] && !inc_hit[i]) begin
                if (cnt[i] != '0)
                    cnt_nxt[i] = cnt[i] - CNT_W'(1);
                else
                    underflow_now = 1'b1;
            end
            all_zero_nxt = all_zero_nxt & (cnt_nxt[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                cnt[i] <= '0;
            busy_vec     <= '0;
            wb_underflow <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i]      <= cnt_nxt[i];
                busy_vec[i] <= (cnt_nxt[i] != '0);
            end
            wb_underflow <= wb_underflow | underflow_now;
            if (bus.dec_stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

    // drain_done is loaded together with the state so it marks DRAINED with no extra delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            drain_done <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    drain_done <= 1'b0;
                    if (drain_req)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!drain_req) begin
                        state      <= ST_RUN;
                        drain_done <= 1'b0;
                    end else if (all_zero_nxt) begin
                        state      <= ST_DRAINED;
                        drain_done <= 1'b1;
                    end else begin
                        drain_done <= 1'b0;
                    end
                end
                ST_DRAINED: begin
                    if (!drain_req) begin
                        state      <= ST_RUN;
                        drain_done <= 1'b0;
                    end else begin
                        drain_done <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
